// File: rtl/data_memory_bytelane_pkg.sv
// rtl/data_memory_bytelane_pkg.sv - shared funct3 codes, FSM states and lane-mask helper
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    typedef struct packed {
        logic [3:0] mask;
        logic       misaligned;
    } lane_t;

    // Size comes from funct3[1:0] so LBU/LHU share the LB/LH lane rules;
    // size 11 never reaches the array because it is rejected as illegal.
    function automatic lane_t lane_info(input logic [2:0] funct3, input logic [1:0] off);
        lane_t r;
        r.mask       = 4'b0000;
        r.misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: r.mask = 4'b0001 << off;
            2'b01: begin
                r.mask       = 4'b0011 << off;
                r.misaligned = off[0];
            end
            2'b10: begin
                r.mask       = 4'b1111;
                r.misaligned = |off;
            end
            default: r.misaligned = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// rtl/data_memory_bytelane_if.sv - MEM-stage load/store bus between pipeline and data memory
interface data_memory_bytelane_if;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        RE;
    logic [2:0]  FUNCT3;
    logic [31:0] RD;
    logic        RD_VALID;
    logic        ERR;
    logic        BUSY;

    modport master (output A, WD, WE, RE, FUNCT3, input RD, RD_VALID, ERR, BUSY);
    modport slave  (input A, WD, WE, RE, FUNCT3, output RD, RD_VALID, ERR, BUSY);
endinterface

// File: rtl/data_memory_bytelane_load_extend.sv
// rtl/data_memory_bytelane_load_extend.sv - byte/half select with sign or zero extension
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane(s) and widen them according to the load type
    always_comb begin
        byte_sel = word_i[8*off_i +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// rtl/data_memory_bytelane.sv - byte-lane data memory with registered loads and post-reset clear
module data_memory_bytelane
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
)(
    input logic                  CLK,
    input logic                  RST,
    data_memory_bytelane_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [AW-1:0]     clr_cnt_q;
    logic              rd_valid_q;
    logic              err_q;
    logic [DATA_W-1:0] word_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;

    logic [AW-1:0]     idx;
    logic [1:0]        off;
    lane_t             lane;
    logic              illegal;
    logic              ready;
    logic              reject;
    logic              do_store;
    logic              do_load;
    logic [31:0]       wdata;
    logic              unused_addr;

    assign idx         = bus.A[AW+1:2];
    assign off         = bus.A[1:0];
    assign unused_addr = ^bus.A[31:AW+2];

    // Decode legality and qualify the request; a store always wins over a load
    always_comb begin
        lane     = lane_info(bus.FUNCT3, off);
        illegal  = (bus.FUNCT3 == 3'b011) || (bus.FUNCT3 == 3'b110) || (bus.FUNCT3 == 3'b111)
                   || (bus.WE && ((bus.FUNCT3 == F3_BU) || (bus.FUNCT3 == F3_HU)));
        ready    = RST && (state_q == ST_READY);
        reject   = ready && (bus.WE || bus.RE) && (illegal || lane.misaligned);
        do_store = ready && bus.WE && !reject;
        do_load  = ready && bus.RE && !bus.WE && !reject;
        case (bus.FUNCT3[1:0])
            2'b00:   wdata = {4{bus.WD[7:0]}};
            2'b01:   wdata = {2{bus.WD[15:0]}};
            default: wdata = bus.WD;
        endcase
    end

    // Array writes: zero fill while clearing, otherwise per-lane store
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (do_store) begin
                for (int l = 0; l < 4; l++) begin
                    if (lane.mask[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    // Clear/ready FSM plus registered load capture and status strobes
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            word_q     <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
        end else begin
            rd_valid_q <= do_load;
            err_q      <= reject;
            if (do_load) begin
                word_q <= mem[idx];
                off_q  <= off;
                f3_q   <= bus.FUNCT3;
            end
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(DEPTH - 1)) state_q <= ST_READY;
                end
                default: state_q <= ST_READY;
            endcase
        end
    end

    load_extend u_load_extend (
        .word_i   (word_q),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (bus.RD)
    );

    assign bus.RD_VALID = rd_valid_q;
    assign bus.ERR      = err_q;
    assign bus.BUSY     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb/tb_data_memory_bytelane.sv - directed self-checking bench for data_memory_bytelane
module tb_data_memory_bytelane;
    import mem_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;

    data_memory_bytelane_if bus();

    data_memory_bytelane #(.DATA_W(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.WE = 1'b0; bus.RE = 1'b0; bus.FUNCT3 = F3_W; bus.A = '0; bus.WD = '0;
    endtask

    task automatic req(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        bus.WE = we; bus.RE = re; bus.FUNCT3 = f3; bus.A = a; bus.WD = wd;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
        req(1'b0, 1'b1, f3, a, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.RD_VALID}, 32'h1);
        chk({tag, "_rd"}, bus.RD, exp);
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (bus.BUSY && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk(tag, n, DEPTH);
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, bus.BUSY}, 32'h1);
        chk("rst_rd", bus.RD, 32'h0);
        chk("rst_valid", {31'h0, bus.RD_VALID}, 32'h0);
        chk("rst_err", {31'h0, bus.ERR}, 32'h0);

        rst = 1'b1;
        n = 0;
        while (bus.BUSY && n < 100) begin
            n++;
            if (n == 3) begin bus.RE = 1'b1; bus.FUNCT3 = F3_W; bus.A = 32'h0; end
            @(posedge clk); #1;
            if (n == 3) begin
                idle();
                chk("busy_lw_valid", {31'h0, bus.RD_VALID}, 32'h0);
                chk("busy_lw_err", {31'h0, bus.ERR}, 32'h0);
            end
        end
        chk("clear_cycles", n, DEPTH);

        load_chk("clr_w10", F3_W, 32'h10, 32'h0);
        load_chk("clr_w3c", F3_W, 32'h3C, 32'h0);

        req(1'b1, 1'b0, F3_W, 32'h10, 32'hDEADBEEF);
        chk("sw_err", {31'h0, bus.ERR}, 32'h0);
        chk("sw_valid", {31'h0, bus.RD_VALID}, 32'h0);
        req(1'b1, 1'b0, F3_B, 32'h11, 32'h00000080);
        req(1'b1, 1'b0, F3_H, 32'h12, 32'h00001234);
        load_chk("lw10", F3_W, 32'h10, 32'h123480EF);
        load_chk("lb11", F3_B, 32'h11, 32'hFFFFFF80);
        load_chk("lbu11", F3_BU, 32'h11, 32'h00000080);
        load_chk("lh12", F3_H, 32'h12, 32'h00001234);
        load_chk("lhu10", F3_HU, 32'h10, 32'h000080EF);

        req(1'b1, 1'b0, F3_W, 32'h21, 32'h11111111);
        chk("sw_mis_err", {31'h0, bus.ERR}, 32'h1);
        chk("sw_mis_valid", {31'h0, bus.RD_VALID}, 32'h0);
        load_chk("w20_kept", F3_W, 32'h20, 32'h0);
        load_chk("lw10_again", F3_W, 32'h10, 32'h123480EF);
        req(1'b0, 1'b1, F3_H, 32'h23, 32'h0);
        chk("lh_mis_err", {31'h0, bus.ERR}, 32'h1);
        chk("lh_mis_valid", {31'h0, bus.RD_VALID}, 32'h0);
        chk("lh_mis_rd_hold", bus.RD, 32'h123480EF);
        @(posedge clk); #1;
        chk("err_one_cycle", {31'h0, bus.ERR}, 32'h0);
        req(1'b0, 1'b1, 3'b011, 32'h0, 32'h0);
        chk("f3_011_err", {31'h0, bus.ERR}, 32'h1);
        req(1'b1, 1'b0, F3_BU, 32'h20, 32'h000000FF);
        chk("sbu_err", {31'h0, bus.ERR}, 32'h1);
        load_chk("sbu_no_write", F3_W, 32'h20, 32'h0);

        req(1'b1, 1'b0, F3_W, 4 * DEPTH + 8, 32'hA5A5A5A5);
        load_chk("wrap_w8", F3_W, 32'h8, 32'hA5A5A5A5);

        req(1'b1, 1'b1, F3_W, 32'h4, 32'h1);
        chk("werd_valid", {31'h0, bus.RD_VALID}, 32'h0);
        chk("werd_err", {31'h0, bus.ERR}, 32'h0);
        load_chk("lw4", F3_W, 32'h4, 32'h1);

        bus.RE = 1'b1; bus.FUNCT3 = F3_W; bus.A = 32'h4;
        @(posedge clk); #1;
        chk("b2b0_valid", {31'h0, bus.RD_VALID}, 32'h1);
        chk("b2b0_rd", bus.RD, 32'h1);
        bus.A = 32'h8;
        @(posedge clk); #1;
        chk("b2b1_valid", {31'h0, bus.RD_VALID}, 32'h1);
        chk("b2b1_rd", bus.RD, 32'hA5A5A5A5);
        bus.A = 32'h10;
        @(posedge clk); #1;
        chk("b2b2_valid", {31'h0, bus.RD_VALID}, 32'h1);
        chk("b2b2_rd", bus.RD, 32'h123480EF);
        idle();
        @(posedge clk); #1;
        chk("b2b_end_valid", {31'h0, bus.RD_VALID}, 32'h0);
        chk("b2b_end_rd_hold", bus.RD, 32'h123480EF);

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_clear_busy", {31'h0, bus.BUSY}, 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_clear_rst_busy", {31'h0, bus.BUSY}, 32'h1);
        rst = 1'b1;
        count_busy("restart_cycles");
        load_chk("reclear_w10", F3_W, 32'h10, 32'h0);

        req(1'b1, 1'b0, F3_W, 32'h10, 32'h00000055);
        load_chk("pre_rst_load", F3_W, 32'h10, 32'h00000055);
        bus.RE = 1'b1; bus.FUNCT3 = F3_W; bus.A = 32'h10;
        rst = 1'b0;
        @(posedge clk); #1;
        idle();
        chk("rst_load_valid", {31'h0, bus.RD_VALID}, 32'h0);
        chk("rst_load_rd", bus.RD, 32'h0);
        chk("rst_load_busy", {31'h0, bus.BUSY}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised successor to the core's word-only data memory. It supports RISC-V byte, halfword and word loads and stores selected by funct3, with byte-lane write enables and sign/zero extension. Reads are registered with a valid strobe, misaligned and illegal accesses are flagged, and an optional hardware clear sequence runs after reset. It sits in the MEM stage between the ALU result/rs2 path and the write-back mux.

## Interface
- DATA_W, 32: data width; fixed at 32 (RV32), kept as a parameter for the package.
- DEPTH, 1024: number of 32-bit words; power of two, at least 4.
- CLEAR_ON_RESET, 1: 1 zeroes the array after reset; 0 skips the clear.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- A  in  32  byte address.
- WD  in  32  store data, right-aligned (rs2).
- WE  in  1  store request.
- RE  in  1  load request.
- FUNCT3  in  3  access size/sign, RISC-V encoding.
- RD  out  32  load result, extended to 32 bits.
- RD_VALID  out  1  one-cycle pulse: RD holds a new load result.
- ERR  out  1  one-cycle pulse: misaligned or illegal access rejected.
- BUSY  out  1  clear sequence in progress; requests ignored.

## Operation
- Word index = A[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes. Byte offset = A[1:0].
- FUNCT3 encodings:
  - 000: LB/SB.
  - 001: LH/SH.
  - 010: LW/SW.
  - 100: LBU.
  - 101: LHU.
  - 100 and 101 with WE are illegal.
  - 011, 110 and 111 are always illegal.
- Alignment: halfword requires A[0]=0; word requires A[1:0]=00. Bytes are always aligned.
- Store:
  - Byte-lane mask = 0001, 0011 or 1111, shifted left by the byte offset.
  - WD is replicated into the lanes (byte into all four, half into both halves).
  - Only masked lanes are written.
- Load:
  - Select byte/half by offset.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Rejected access (misaligned/illegal): no array write; ERR=1 next cycle; RD_VALID stays 0; RD unchanged.
- WE and RE both high: the store is performed, the load is ignored, and no RD_VALID is issued.
- State machine CLEAR → READY:
  - CLEAR writes zero to word clr_cnt each cycle, with clr_cnt counting 0..DEPTH-1.
  - CLEAR goes to READY after writing DEPTH-1.
  - With CLEAR_ON_RESET=0, reset goes directly to READY.
  - BUSY=1 exactly while in CLEAR.
  - WE/RE in CLEAR are ignored, with no ERR.

## Timing
- Reset values: RD=0, RD_VALID=0, ERR=0, clr_cnt=0. State is CLEAR (BUSY=1) if CLEAR_ON_RESET, else READY (BUSY=0).
- While RST=0 is held, state and counter stay at their reset values. The clear takes exactly DEPTH cycles after the first edge with RST=1.
- RST=0 mid-clear or mid-access: the clear restarts from 0, and a pending RD_VALID/ERR is cancelled.
- Load latency is 1 cycle. The request is sampled at edge N; RD/RD_VALID are valid after edge N, i.e. during cycle N+1.
- Back-to-back loads every cycle give RD_VALID=1 continuously.
- RD holds its value until the next valid load.
- A store at edge N is visible to a load sampled at edge N+1 or later. There is no same-edge forwarding, because a simultaneous WE+RE drops the read.
- ERR and RD_VALID are never both 1.

## Structure
- Shared package `mem_pkg` holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {ST_CLEAR, ST_READY}.
  - Function computing the lane mask and misalignment flag from funct3 and A[1:0].
- One natural sub-module: `load_extend`, the combinational byte/half select plus sign/zero extension, fed by registered word, offset and funct3.
- The array is reg [31:0] mem [DEPTH-1:0] with per-lane writes, so it infers a byte-enable RAM.

## Test plan
- Reset clear (DEPTH=16, CLEAR_ON_RESET=1):
  - Release RST → BUSY high for exactly 16 cycles.
  - A LW issued during BUSY → no RD_VALID, no ERR.
  - After BUSY drops, LW of any word → 0x00000000.
- Store/load, aligned:
  - SW 0xDEADBEEF @0x10; SB 0x80 @0x11; SH 0x1234 @0x12; then LW @0x10 → 0x12348 0EF, i.e. 0x123480EF.
  - LB @0x11 → 0xFFFFFF80.
  - LBU @0x11 → 0x00000080.
  - LH @0x12 → 0x00001234.
- Misalignment:
  - SW @0x21 → ERR pulse, word 0x20 unchanged.
  - LH @0x23 → ERR, no RD_VALID, RD holds its prior value.
  - FUNCT3=011 → ERR.
- Wrap-around: SW 0xA5A5A5A5 @(4*DEPTH+8) then LW @0x8 → 0xA5A5A5A5.
- Simultaneous and back-to-back:
  - WE+RE @0x4 with WD=0x1 → store done, no RD_VALID.
  - Next-cycle LW @0x4 → 0x1.
  - Three consecutive LWs → RD_VALID high for 3 cycles, each with a 1-cycle latency.
- Reset mid-operation:
  - RST=0 during clear count 7 → count restarts at 0, full DEPTH cycles of BUSY after release.
  - RST=0 coincident with a load edge → RD_VALID=0, RD=0.
